// File: rtl/game_state_controller_pkg.sv
// Shared widths, state encoding and playfield constants for the game-flow controller.
package game_state_controller_pkg;

  localparam int unsigned STATE_W     = 3;
  localparam int unsigned FRAME_CNT_W = 8;
  localparam int unsigned FROG_Y_W    = 9;
  localparam int unsigned LIVES_W     = 2;
  localparam int unsigned LEVEL_W     = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 3'd0,
    S_PLAY     = 3'd1,
    S_HIT      = 3'd2,
    S_LEVEL_UP = 3'd3,
    S_OVER     = 3'd4
  } state_e;

  // Frog rows in pixels; the goal is the top row of the playfield.
  localparam logic [FROG_Y_W-1:0] C_GOAL_Y       = 9'd0;
  localparam logic [FROG_Y_W-1:0] C_FROG_START_Y = 9'd448;

endpackage

// File: rtl/game_state_controller_frame_countdown.sv
// Loadable 8-bit frame countdown; decrements on enable, saturates at zero,
// and reports a registered non-zero flag.
module frame_countdown
  import game_state_controller_pkg::*;
(
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_Load,
  input  logic [FRAME_CNT_W-1:0] i_Load_Val,
  input  logic                   i_Dec,
  output logic [FRAME_CNT_W-1:0] o_Count,
  output logic                   o_Busy
);

  logic [FRAME_CNT_W-1:0] count_q, count_d;
  logic                   busy_q;

  // Load wins over decrement so a tick on the load cycle is not counted.
  always_comb begin
    count_d = count_q;
    if (i_Load) begin
      count_d = i_Load_Val;
    end else if (i_Dec && (count_q != '0)) begin
      count_d = count_q - FRAME_CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= (count_d != '0);
    end
  end

  assign o_Count = count_q;
  assign o_Busy  = busy_q;

endmodule

// File: rtl/game_state_controller.sv
// Game-flow controller: lives, level and phase tracking driven by collisions,
// goal arrival and video frame ticks.
module game_state_controller
  import game_state_controller_pkg::*;
#(
  parameter int unsigned HIT_FRAMES   = 60,
  parameter int unsigned LEVEL_FRAMES = 30,
  parameter int unsigned GRACE_FRAMES = 45,
  parameter int unsigned INIT_LIVES   = 3,
  parameter int unsigned MAX_LEVEL    = 15
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Has_Collided,
  input  logic [FROG_Y_W-1:0] i_Frog_Y,
  input  logic                i_Frame_Tick,
  input  logic                i_Start,
  output logic [STATE_W-1:0]  o_State,
  output logic [LIVES_W-1:0]  o_Lives,
  output logic [LEVEL_W-1:0]  o_Level,
  output logic                o_Freeze,
  output logic                o_Respawn,
  output logic                o_Game_Over,
  output logic                o_Invulnerable
);

  state_e                 state_q, state_d;
  logic [LIVES_W-1:0]     lives_q, lives_d;
  logic [LEVEL_W-1:0]     level_q, level_d;
  logic                   respawn_q, respawn_d;
  logic                   freeze_q, freeze_d;
  logic                   game_over_q, game_over_d;

  logic [FRAME_CNT_W-1:0] timer_count, grace_count;
  logic                   timer_busy, grace_busy;
  logic                   timer_load, timer_dec, grace_dec;
  logic [FRAME_CNT_W-1:0] timer_load_val;

  logic start_c, hit_c, goal_c, expire_c, in_timed_c;

  assign in_timed_c = (state_q == S_HIT) || (state_q == S_LEVEL_UP);
  assign start_c    = i_Start && ((state_q == S_IDLE) || (state_q == S_OVER));
  assign hit_c      = (state_q == S_PLAY) && i_Has_Collided && (grace_count == '0);
  assign goal_c     = (state_q == S_PLAY) && !hit_c && (i_Frog_Y == C_GOAL_Y);
  // Expires on the tick that brings the timer to zero, or the first tick if already zero.
  assign expire_c   = in_timed_c && i_Frame_Tick &&
                      (!timer_busy || (timer_count == FRAME_CNT_W'(1)));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_OVER: if (start_c) state_d = S_PLAY;
      S_PLAY: begin
        if (hit_c)       state_d = S_HIT;
        else if (goal_c) state_d = S_LEVEL_UP;
      end
      S_HIT:      if (expire_c) state_d = (lives_q == '0) ? S_OVER : S_PLAY;
      S_LEVEL_UP: if (expire_c) state_d = S_PLAY;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lives_d        = lives_q;
    level_d        = level_q;
    respawn_d      = 1'b0;
    timer_load     = hit_c || goal_c;
    timer_load_val = hit_c ? FRAME_CNT_W'(HIT_FRAMES) : FRAME_CNT_W'(LEVEL_FRAMES);
    if (start_c) begin
      lives_d   = LIVES_W'(INIT_LIVES);
      level_d   = '0;
      respawn_d = 1'b1;
    end
    if (hit_c && (lives_q != '0)) begin
      lives_d = lives_q - LIVES_W'(1);
    end
    if (goal_c && (level_q < LEVEL_W'(MAX_LEVEL))) begin
      level_d = level_q + LEVEL_W'(1);
    end
    if (expire_c && !((state_q == S_HIT) && (lives_q == '0))) begin
      respawn_d = 1'b1;
    end
    freeze_d    = (state_d != S_PLAY);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      lives_q     <= LIVES_W'(INIT_LIVES);
      level_q     <= '0;
      respawn_q   <= 1'b0;
      freeze_q    <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      lives_q     <= lives_d;
      level_q     <= level_d;
      respawn_q   <= respawn_d;
      freeze_q    <= freeze_d;
      game_over_q <= game_over_d;
    end
  end

  assign timer_dec = in_timed_c && i_Frame_Tick;
  assign grace_dec = (state_q == S_PLAY) && i_Frame_Tick;

  frame_countdown u_phase_timer (
    .i_Clk      (i_Clk),
    .i_Rst_n    (i_Rst_n),
    .i_Load     (timer_load),
    .i_Load_Val (timer_load_val),
    .i_Dec      (timer_dec),
    .o_Count    (timer_count),
    .o_Busy     (timer_busy)
  );

  frame_countdown u_grace_timer (
    .i_Clk      (i_Clk),
    .i_Rst_n    (i_Rst_n),
    .i_Load     (respawn_d),
    .i_Load_Val (FRAME_CNT_W'(GRACE_FRAMES)),
    .i_Dec      (grace_dec),
    .o_Count    (grace_count),
    .o_Busy     (grace_busy)
  );

  assign o_State        = state_q;
  assign o_Lives        = lives_q;
  assign o_Level        = level_q;
  assign o_Freeze       = freeze_q;
  assign o_Respawn      = respawn_q;
  assign o_Game_Over    = game_over_q;
  assign o_Invulnerable = grace_busy;

endmodule

// File: tb/tb_game_state_controller.sv
// Randomized and directed bench for game_state_controller against a
// frame-counting reference model of the game rules.
module tb_game_state_controller;

  localparam int ST_IDLE = 0, ST_PLAY = 1, ST_HIT = 2, ST_LVL = 3, ST_OVER = 4;
  localparam int HIT_F = 60, LVL_F = 30, GRACE_F = 45, INIT_L = 3, MAX_LVL = 15;

  logic       i_Clk = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       i_Has_Collided = 1'b0;
  logic [8:0] i_Frog_Y = 9'd200;
  logic       i_Frame_Tick = 1'b0;
  logic       i_Start = 1'b0;
  logic [2:0] o_State;
  logic [1:0] o_Lives;
  logic [3:0] o_Level;
  logic       o_Freeze, o_Respawn, o_Game_Over, o_Invulnerable;

  game_state_controller dut (
    .i_Clk          (i_Clk),
    .i_Rst_n        (i_Rst_n),
    .i_Has_Collided (i_Has_Collided),
    .i_Frog_Y       (i_Frog_Y),
    .i_Frame_Tick   (i_Frame_Tick),
    .i_Start        (i_Start),
    .o_State        (o_State),
    .o_Lives        (o_Lives),
    .o_Level        (o_Level),
    .o_Freeze       (o_Freeze),
    .o_Respawn      (o_Respawn),
    .o_Game_Over    (o_Game_Over),
    .o_Invulnerable (o_Invulnerable)
  );

  always #5 i_Clk = ~i_Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: game phase plus frames remaining on the phase timer and grace period.
  int m_state, m_lives, m_level, m_timer, m_grace, m_respawn;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = ST_IDLE; m_lives = INIT_L; m_level = 0;
    m_timer = 0; m_grace = 0; m_respawn = 0;
  endtask

  task automatic model_begin_play();
    m_respawn = 1;
    m_grace   = GRACE_F;
    m_state   = ST_PLAY;
  endtask

  task automatic model_step(input bit col, input int y, input bit tick, input bit start);
    bit vulnerable;
    m_respawn = 0;
    case (m_state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          m_lives = INIT_L;
          m_level = 0;
          model_begin_play();
        end
      end
      ST_PLAY: begin
        vulnerable = (m_grace == 0);
        if (tick && m_grace > 0) m_grace--;
        if (col && vulnerable) begin
          m_lives--;
          m_timer = HIT_F;
          m_state = ST_HIT;
        end else if (y == 0) begin
          if (m_level < MAX_LVL) m_level++;
          m_timer = LVL_F;
          m_state = ST_LVL;
        end
      end
      default: begin
        if (tick) begin
          if (m_timer <= 1) begin
            m_timer = 0;
            if (m_state == ST_HIT && m_lives == 0) m_state = ST_OVER;
            else model_begin_play();
          end else begin
            m_timer--;
          end
        end
      end
    endcase
  endtask

  task automatic check_all();
    check_eq("state",     int'(o_State),        m_state);
    check_eq("lives",     int'(o_Lives),        m_lives);
    check_eq("level",     int'(o_Level),        m_level);
    check_eq("freeze",    int'(o_Freeze),       (m_state != ST_PLAY) ? 1 : 0);
    check_eq("respawn",   int'(o_Respawn),      m_respawn);
    check_eq("game_over", int'(o_Game_Over),    (m_state == ST_OVER) ? 1 : 0);
    check_eq("invuln",    int'(o_Invulnerable), (m_grace != 0) ? 1 : 0);
  endtask

  task automatic run_cycle(input bit col, input int y, input bit tick, input bit start);
    i_Has_Collided = col;
    i_Frog_Y       = 9'(y);
    i_Frame_Tick   = tick;
    i_Start        = start;
    @(posedge i_Clk);
    model_step(col, y, tick, start);
    @(negedge i_Clk);
    check_all();
  endtask

  task automatic rand_cycle(input int col_pct, input int goal_pct, input int start_pct);
    bit col, tick, start;
    int y;
    col   = ($urandom_range(0, 99) < col_pct);
    start = ($urandom_range(0, 99) < start_pct);
    tick  = ($urandom_range(0, 2) == 0);
    y     = ($urandom_range(0, 99) < goal_pct) ? 0 : int'($urandom_range(1, 479));
    run_cycle(col, y, tick, start);
  endtask

  // Tick every cycle until the frog is in play with no grace left.
  task automatic wait_vulnerable();
    int n = 0;
    while (!(m_state == ST_PLAY && m_grace == 0) && n < 400) begin
      run_cycle(0, 200, 1, (m_state == ST_IDLE || m_state == ST_OVER));
      n++;
    end
    if (n >= 400) check_eq("wait_vulnerable_timeout", n, 0);
  endtask

  initial begin
    int ticks;
    model_reset();
    repeat (3) @(negedge i_Clk);
    check_all();
    i_Rst_n = 1'b1;

    run_cycle(0, 200, 0, 1);
    // Collisions during grace are ignored.
    for (int i = 0; i < 10; i++) run_cycle(1, 200, 1, 0);

    // Lose all lives; first hit coincides with the goal row.
    for (int k = 0; k < 4 && m_state != ST_OVER; k++) begin
      wait_vulnerable();
      run_cycle(1, (k == 0) ? 0 : 150, 0, 0);
      for (int n = 0; n < 300 && m_state == ST_HIT; n++)
        run_cycle(0, 200, 1'($urandom_range(0, 1)), 0);
    end
    check_eq("reached_over", int'(o_State), ST_OVER);
    for (int i = 0; i < 5; i++) run_cycle(1, 0, 1, 0);
    run_cycle(0, 200, 1, 1);

    // Sixteen goal visits, each holding LEVEL_UP for LVL_F ticks.
    for (int g = 0; g < 16; g++) begin
      for (int n = 0; n < 100 && m_state != ST_PLAY; n++) run_cycle(0, 200, 1, 0);
      run_cycle(0, 0, 0, 0);
      ticks = 0;
      while (int'(o_State) == ST_LVL && ticks < 200) begin
        run_cycle(0, 200, 1, 0);
        ticks++;
      end
      check_eq("level_hold_frames", ticks, LVL_F);
    end
    check_eq("level_saturated", int'(o_Level), MAX_LVL);

    // Asynchronous reset in the middle of a hit countdown.
    wait_vulnerable();
    run_cycle(1, 200, 0, 0);
    for (int i = 0; i < 5; i++) run_cycle(0, 200, 1, 0);
    #2 i_Rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge i_Clk);
    check_all();
    i_Rst_n = 1'b1;
    run_cycle(0, 200, 0, 1);

    for (int i = 0; i < 2000; i++) rand_cycle(6, 3, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_state_controller.md
# game_state_controller

Game-flow controller directly downstream of the frog/car collision checker. It consumes the registered collision flag and the frog's row, and tracks lives, level and game phase. It issues a one-cycle respawn pulse to the frog mover and a freeze level to the frog and car movers. Timing uses frame ticks from the VGA sync generator, so freeze, death and grace periods are measured in video frames.

## Interface
- HIT_FRAMES, 60: frames frozen after a collision (death animation).
- LEVEL_FRAMES, 30: frames frozen after reaching the goal row.
- GRACE_FRAMES, 45: frames after a respawn during which collisions are ignored.
- INIT_LIVES, 3: lives loaded on reset and on start. Range 1..3.
- MAX_LEVEL, 15: level saturation value.
- i_Clk  in  1  system/pixel clock.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Has_Collided  in  1  registered collision flag from the collision checker.
- i_Frog_Y  in  9  frog top-left Y, in pixels.
- i_Frame_Tick  in  1  one-cycle pulse per frame, at the start of vertical blanking.
- i_Start  in  1  debounced one-cycle start pulse.
- o_State  out  3  current FSM state encoding.
- o_Lives  out  2  remaining lives.
- o_Level  out  4  current level; the car-speed selector uses it.
- o_Freeze  out  1  high: frog input and car motion are disabled.
- o_Respawn  out  1  one-cycle pulse: frog returns to its start tile.
- o_Game_Over  out  1  high while in S_OVER.
- o_Invulnerable  out  1  high while the grace period is running.

## Operation
- States are S_IDLE, S_PLAY, S_HIT, S_LEVEL_UP and S_OVER.
- S_IDLE:
  - On i_Start: load lives = INIT_LIVES, level = 0, pulse o_Respawn, load grace = GRACE_FRAMES, go to S_PLAY.
- S_PLAY, in priority order:
  1. i_Start is ignored.
  2. If i_Has_Collided is high and grace == 0: lives -= 1, load timer = HIT_FRAMES, go to S_HIT.
  3. Else if i_Frog_Y == C_GOAL_Y: level = min(level+1, MAX_LEVEL), load timer = LEVEL_FRAMES, go to S_LEVEL_UP.
  - Collision therefore wins over goal in the same cycle.
- S_HIT: timer decrements on each i_Frame_Tick. When timer == 0:
  - If lives == 0: go to S_OVER.
  - Else: pulse o_Respawn, load grace, go to S_PLAY.
- S_LEVEL_UP: timer decrements on each i_Frame_Tick. When timer == 0: pulse o_Respawn, load grace, go to S_PLAY. Lives are unchanged.
- S_OVER:
  - o_Game_Over is high.
  - On i_Start: same actions as from S_IDLE.
  - i_Has_Collided is ignored.
- Grace counter:
  - Decrements on i_Frame_Tick only in S_PLAY, and saturates at 0.
  - o_Invulnerable = (grace != 0).
- Arithmetic: lives are 2-bit and never decrement below 0. The S_PLAY collision branch is only reachable with lives ≥ 1.
- o_Freeze = 1 in S_IDLE, S_HIT, S_LEVEL_UP and S_OVER; 0 only in S_PLAY.
- A collision in any state other than S_PLAY has no effect.

## Timing
- Reset values: o_State = S_IDLE, o_Lives = INIT_LIVES, o_Level = 0, o_Freeze = 1, o_Respawn = 0, o_Game_Over = 0, o_Invulnerable = 0. Timer = 0, grace = 0.
- Reset mid-operation: all registers return to reset values immediately and asynchronously. Any o_Respawn pulse in flight is cut.
- All outputs are registered.
- Collision latency: if i_Has_Collided is high at edge k, then after edge k S_HIT is entered, o_Lives is decremented and o_Freeze is high.
- Timer expiry: the transition happens on the i_Frame_Tick edge that makes the timer 0. o_Respawn is high for exactly that following cycle.
- Frame ticks during the transition cycle are not double-counted.
- A timer loaded with 0 frames expires on the first i_Frame_Tick.
- i_Start coinciding with i_Frame_Tick in S_OVER: start wins.

## Structure
- Constants.v holds:
  - State encodings S_IDLE=0, S_PLAY=1, S_HIT=2, S_LEVEL_UP=3, S_OVER=4.
  - C_GOAL_Y = 0 and C_FROG_START_Y, alongside the existing C_LINE_n_Y constants.
- One sub-module, frame_countdown, is instantiated twice, once for the phase timer and once for the grace counter:
  - 8-bit counter with load, a decrement enabled by i_Frame_Tick, saturation at zero, and a zero flag.

## Test plan
- Reset, then pulse i_Start → S_PLAY, o_Lives = 3, o_Level = 0, o_Respawn high exactly 1 cycle, o_Invulnerable = 1.
- Collision at 10 frames after start (grace = 45) → ignored. Collision again after 46 frames → S_HIT, o_Lives = 2, o_Freeze = 1. After 60 frame ticks → o_Respawn pulse, then S_PLAY.
- Three spaced collisions → o_Lives = 0. After the final 60-frame HIT → S_OVER with o_Game_Over = 1, and no respawn pulse.
- i_Frog_Y = 0 and i_Has_Collided = 1 in the same cycle (grace expired) → S_HIT, and level stays 0.
- Goal reached 16 times → o_Level saturates at 15, and each visit holds S_LEVEL_UP for 30 frames.
- i_Rst_n low during S_HIT mid-count → immediate S_IDLE, o_Lives = 3, o_Freeze = 1. After release, i_Start restarts cleanly.
